// File: rtl/sch_dec_pkg.sv
// Shared types and the decode function for the pipelined 2-to-4 decoder.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package sch_dec_pkg;

    localparam int CODE_W = 2;
    localparam int LINES  = 4;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [LINES-1:0]  onehot_t;

    // One buffered decode: the decoded word is stored next to the inputs
    // that produced it so the round-trip echo and the counters see the
    // same entry the consumer sees.
    typedef struct packed {
        logic    en;
        code_t   code;
        onehot_t onehot;
    } entry_t;

    // Active-high one-hot decode; a disabled code yields an all-zero word.
    function automatic onehot_t dec2to4(input code_t code, input logic en);
        onehot_t word;
        word = '0;
        if (en) begin
            word[code] = 1'b1;
        end
        return word;
    endfunction

endpackage

// File: rtl/sch_fifo2.sv
// Generic 2-entry FIFO with registered full/empty flags.
// Latency: a write into an empty FIFO is readable the cycle after the write edge.
// Backpressure: wr_rdy = !full (registered, independent of rd_rdy); rd_vld = !empty.
//
// Ports: clk/rst (sync, active-high), wr_vld/wr_rdy/wr_dat write side,
//        rd_vld/rd_rdy/rd_dat read side (rd_dat is the head entry).
module sch_fifo2 #(
    parameter type T = sch_dec_pkg::entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_vld,
    output logic wr_rdy,
    input  T     wr_dat,
    output logic rd_vld,
    input  logic rd_rdy,
    output T     rd_dat
);

    T     mem [2];
    logic wr_ptr;
    logic rd_ptr;
    logic full_q;
    logic empty_q;
    logic push;
    logic pop;

    assign push   = wr_vld & ~full_q;
    assign pop    = rd_rdy & ~empty_q;
    assign wr_rdy = ~full_q;
    assign rd_vld = ~empty_q;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            mem[0]  <= '0;
            mem[1]  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Push-and-pop together can only happen at occupancy 1, which
            // leaves both flags unchanged.
            case ({push, pop})
                2'b10: begin
                    empty_q <= 1'b0;
                    full_q  <= (~wr_ptr == rd_ptr);
                end
                2'b01: begin
                    full_q  <= 1'b0;
                    empty_q <= (~rd_ptr == wr_ptr);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/sch_2_to_4_dec_pipe.sv
// Registered, flow-controlled 2-to-4 one-hot decoder with per-line hit counters.
// Latency: 1 cycle from push into an empty buffer to out_valid; 1 word/cycle sustained.
// Backpressure: 2-entry buffer; in_ready is low whenever the buffer is full, regardless of out_ready.
//
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_code/in_en producer side;
//        out_valid/out_ready/out_onehot/out_code/out_en consumer side;
//        clr_cnt clears the counters; hit_cnt packs line k at [k*CNT_W +: CNT_W].
module sch_2_to_4_dec_pipe
    import sch_dec_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter bit OUT_ACT_LOW = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODE_W-1:0]      in_code,
    input  logic                   in_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LINES-1:0]       out_onehot,
    output logic [CODE_W-1:0]      out_code,
    output logic                   out_en,
    input  logic                   clr_cnt,
    output logic [LINES*CNT_W-1:0] hit_cnt
);

    entry_t           wr_entry;
    entry_t           head;
    entry_t           last_q;
    entry_t           shown;
    logic             head_vld;
    logic             pop;
    logic [CNT_W-1:0] cnt_q [LINES];

    // Decode happens once, at push time; the buffer stores the finished word.
    always_comb begin
        wr_entry        = '0;
        wr_entry.en     = in_en;
        wr_entry.code   = in_code;
        wr_entry.onehot = dec2to4(in_code, in_en);
    end

    sch_fifo2 #(
        .T (entry_t)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (in_valid),
        .wr_rdy (in_ready),
        .wr_dat (wr_entry),
        .rd_vld (head_vld),
        .rd_rdy (out_ready),
        .rd_dat (head)
    );

    assign out_valid = head_vld;
    assign pop       = head_vld & out_ready;

    // When the buffer drains, the stale FIFO slot may hold an older entry;
    // presenting the last popped entry instead keeps the outputs quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= '0;
        end else if (pop) begin
            last_q <= head;
        end
    end

    assign shown      = head_vld ? head : last_q;
    assign out_onehot = OUT_ACT_LOW ? ~shown.onehot : shown.onehot;
    assign out_code   = shown.code;
    assign out_en     = shown.en;

    // Hit counters: clear has priority over a same-cycle increment, and
    // each line sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            for (int i = 0; i < LINES; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (pop && head.en) begin
            for (int i = 0; i < LINES; i++) begin
                if (head.code == code_t'(i) && cnt_q[i] != {CNT_W{1'b1}}) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < LINES; i++) begin
            hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule
